// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared pipeline definitions: ALU ops, arbiter state and grant-source codes
package mem_port_arbiter_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_e;

  // Memory-port arbiter FSM encoding
  localparam logic [1:0] ARB_IDLE    = 2'd0;
  localparam logic [1:0] ARB_IF_ACT  = 2'd1;
  localparam logic [1:0] ARB_ME_ACT  = 2'd2;
  localparam logic [1:0] ARB_IF_DROP = 2'd3;

  // Source of a completed memory response awaiting delivery
  localparam logic [1:0] SRC_NONE = 2'd0;
  localparam logic [1:0] SRC_IF   = 2'd1;
  localparam logic [1:0] SRC_ME   = 2'd2;

endpackage

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port memory arbiter between fetch (IF) and data (ME) stages
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_flush,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  input  logic        me_req,
  input  logic        me_we,
  input  logic [31:0] me_addr,
  input  logic [31:0] me_wdata,
  output logic [31:0] me_rdata,
  output logic        me_valid,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        stall_if,
  output logic        stall_me
);

  localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] STARVE_MAX = CW'(STARVE_LIMIT);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] starve_q, starve_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q;
  logic [31:0]   mem_addr_q, mem_wdata_q;
  logic [1:0]    rsp_src_q, rsp_src_d;
  logic          rsp_we_q;
  logic [31:0]   rsp_data_q;
  logic [31:0]   if_rdata_q, me_rdata_q;
  logic          if_valid_q, me_valid_q;

  logic arb_en, if_cand, me_cand, starved, grant_me, grant_if, mem_done;

  // Arbitrate only when idle with no response still on its way back to a requester
  always_comb begin
    arb_en   = (state_q == ARB_IDLE) && (rsp_src_q == SRC_NONE) && !if_valid_q && !me_valid_q;
    if_cand  = if_req && !if_valid_q && !if_flush;
    me_cand  = me_req && !me_valid_q;
    starved  = (starve_q == STARVE_MAX) && if_req;
    grant_me = arb_en && me_cand && !(starved && if_cand);
    grant_if = arb_en && if_cand && !grant_me;
    mem_done = mem_req_q && mem_ready;
  end

  // Next-state logic for the FSM, mem_req, response routing and starvation count
  always_comb begin
    state_d   = state_q;
    mem_req_d = mem_req_q;
    rsp_src_d = SRC_NONE;
    starve_d  = starve_q;
    case (state_q)
      ARB_IDLE: begin
        if (grant_me) begin
          state_d   = ARB_ME_ACT;
          mem_req_d = 1'b1;
        end else if (grant_if) begin
          state_d   = ARB_IF_ACT;
          mem_req_d = 1'b1;
        end
      end
      ARB_IF_ACT: begin
        if (mem_done) begin
          state_d   = ARB_IDLE;
          mem_req_d = 1'b0;
          rsp_src_d = if_flush ? SRC_NONE : SRC_IF;
        end else if (if_flush) begin
          state_d = ARB_IF_DROP;
        end
      end
      ARB_ME_ACT: begin
        if (mem_done) begin
          state_d   = ARB_IDLE;
          mem_req_d = 1'b0;
          rsp_src_d = SRC_ME;
        end
      end
      ARB_IF_DROP: begin
        if (mem_done) begin
          state_d   = ARB_IDLE;
          mem_req_d = 1'b0;
        end
      end
      default: begin
        state_d   = ARB_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
    if (grant_if) begin
      starve_d = '0;
    end else if (grant_me && if_req && (starve_q != STARVE_MAX)) begin
      starve_d = starve_q + CW'(1);
    end
  end

  // Control registers; reset abandons any in-flight transaction
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ARB_IDLE;
      starve_q  <= '0;
      mem_req_q <= 1'b0;
      rsp_src_q <= SRC_NONE;
    end else begin
      state_q   <= state_d;
      starve_q  <= starve_d;
      mem_req_q <= mem_req_d;
      rsp_src_q <= rsp_src_d;
    end
  end

  // Memory command registers, loaded at grant; fetches never write
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else if (grant_me) begin
      mem_we_q    <= me_we;
      mem_addr_q  <= me_addr;
      mem_wdata_q <= me_wdata;
    end else if (grant_if) begin
      mem_we_q    <= 1'b0;
      mem_addr_q  <= if_addr;
      mem_wdata_q <= '0;
    end
  end

  // Capture read data when the memory completes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_data_q <= '0;
      rsp_we_q   <= 1'b0;
    end else if (mem_done) begin
      rsp_data_q <= mem_rdata;
      rsp_we_q   <= mem_we_q;
    end
  end

  // Deliver responses one cycle after capture; a flush in between still kills a fetch
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      if_valid_q <= 1'b0;
      me_valid_q <= 1'b0;
      if_rdata_q <= '0;
      me_rdata_q <= '0;
    end else begin
      if_valid_q <= (rsp_src_q == SRC_IF) && !if_flush;
      me_valid_q <= (rsp_src_q == SRC_ME);
      if ((rsp_src_q == SRC_IF) && !if_flush) begin
        if_rdata_q <= rsp_data_q;
      end
      if ((rsp_src_q == SRC_ME) && !rsp_we_q) begin
        me_rdata_q <= rsp_data_q;
      end
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign if_valid  = if_valid_q;
  assign me_rdata  = me_rdata_q;
  assign me_valid  = me_valid_q;
  assign stall_if  = if_req & ~if_valid_q;
  assign stall_me  = me_req & ~me_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard testbench for mem_port_arbiter
module tb_mem_port_arbiter;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_txn_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        if_req = 1'b0, if_flush = 1'b0;
  logic [31:0] if_addr = '0;
  logic        me_req = 1'b0, me_we = 1'b0;
  logic [31:0] me_addr = '0, me_wdata = '0;
  logic [31:0] if_rdata, me_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        if_valid, me_valid, mem_req, mem_we, mem_ready, stall_if, stall_me;

  int checks = 0;
  int errors = 0;

  int          wait_cfg = 0;
  int          wait_cnt = 0;
  logic        force_ready = 1'b0;
  logic        use_ovr = 1'b0;
  logic [31:0] ovr_data = '0;
  logic [31:0] me_model = '0;
  logic [31:0] if_model = '0;

  mem_txn_t    exp_mem[$];
  logic [31:0] exp_if[$];
  logic [31:0] exp_me[$];

  mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_rdata(if_rdata), .if_valid(if_valid),
    .me_req(me_req), .me_we(me_we), .me_addr(me_addr), .me_wdata(me_wdata),
    .me_rdata(me_rdata), .me_valid(me_valid),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .stall_if(stall_if), .stall_me(stall_me)
  );

  always #5 clk = ~clk;

  // Memory model: configurable wait states, data derived from address unless overridden
  assign mem_ready = (mem_req && (wait_cnt == wait_cfg)) || force_ready;
  assign mem_rdata = use_ovr ? ovr_data : (mem_addr ^ 32'h5A5A_0000);

  always @(posedge clk) begin
    if (mem_req && !mem_ready) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end

  function automatic logic [31:0] mem_val(input logic [31:0] addr);
    return use_ovr ? ovr_data : (addr ^ 32'h5A5A_0000);
  endfunction

  task automatic monitor();
    mem_txn_t    e, got;
    logic [31:0] x;
    forever begin
      @(negedge clk);
      if (!reset && mem_req && mem_ready) begin
        got = {mem_we, mem_addr, mem_wdata};
        checks++;
        if (exp_mem.size() == 0) begin
          errors++;
          $display("FAIL mem_txn unexpected we=%b addr=%h wdata=%h", mem_we, mem_addr, mem_wdata);
        end else begin
          e = exp_mem.pop_front();
          if (got !== e) begin
            errors++;
            $display("FAIL mem_txn got we=%b addr=%h wdata=%h expected we=%b addr=%h wdata=%h",
                     got.we, got.addr, got.wdata, e.we, e.addr, e.wdata);
          end
        end
      end
      if (if_valid === 1'b1) begin
        checks++;
        if (exp_if.size() == 0) begin
          errors++;
          $display("FAIL if_valid unexpected if_rdata=%h", if_rdata);
        end else begin
          x = exp_if.pop_front();
          if (if_rdata !== x) begin
            errors++;
            $display("FAIL if_rdata got %h expected %h", if_rdata, x);
          end
        end
      end
      if (me_valid === 1'b1) begin
        checks++;
        if (exp_me.size() == 0) begin
          errors++;
          $display("FAIL me_valid unexpected me_rdata=%h", me_rdata);
        end else begin
          x = exp_me.pop_front();
          if (me_rdata !== x) begin
            errors++;
            $display("FAIL me_rdata got %h expected %h", me_rdata, x);
          end
        end
      end
    end
  endtask

  task automatic run_me(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    int n;
    mem_txn_t t;
    @(posedge clk); #1;
    me_req = 1'b1; me_we = we; me_addr = addr; me_wdata = wdata;
    t = {we, addr, wdata};
    exp_mem.push_back(t);
    if (!we) me_model = mem_val(addr);
    exp_me.push_back(me_model);
    n = 0;
    do begin @(negedge clk); n++; end while (me_valid !== 1'b1 && n < 60);
    checks++;
    if (me_valid !== 1'b1) begin
      errors++;
      $display("FAIL me_valid_timeout got %b expected 1", me_valid);
    end
    @(posedge clk); #1;
    me_req = 1'b0;
  endtask

  task automatic wait_if_done(input string name);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (if_valid !== 1'b1 && n < 60);
    checks++;
    if (if_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s if_valid_timeout got %b expected 1", name, if_valid);
    end
    @(posedge clk); #1;
    if_req = 1'b0;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    #2;
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_me_valid", {31'd0, me_valid}, 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_me_rdata", me_rdata, 32'd0);
    chk("rst_stall", {30'd0, stall_if, stall_me}, 32'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_if_fetch();
    mem_txn_t t;
    @(posedge clk); #1;
    use_ovr = 1'b1; ovr_data = 32'hDEAD_BEEF; wait_cfg = 0;
    if_req = 1'b1; if_addr = 32'h100;
    t = {1'b0, 32'h100, 32'h0};
    exp_mem.push_back(t);
    exp_if.push_back(32'hDEAD_BEEF);
    @(negedge clk);
    chk("c0_mem_req", {31'd0, mem_req}, 32'd0);
    chk("c0_stall_if", {31'd0, stall_if}, 32'd1);
    @(negedge clk);
    chk("c1_mem_req", {31'd0, mem_req}, 32'd1);
    chk("c1_mem_addr", mem_addr, 32'h100);
    @(negedge clk);
    chk("c2_if_valid", {31'd0, if_valid}, 32'd0);
    @(negedge clk);
    chk("c3_if_valid", {31'd0, if_valid}, 32'd1);
    chk("c3_if_rdata", if_rdata, 32'hDEAD_BEEF);
    chk("c3_stall_if", {31'd0, stall_if}, 32'd0);
    @(posedge clk); #1;
    if_req = 1'b0; use_ovr = 1'b0;
    if_model = 32'hDEAD_BEEF;
  endtask

  task automatic test_priority();
    mem_txn_t t;
    logic me_done, if_done;
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h300;
    me_req = 1'b1; me_we = 1'b1; me_addr = 32'h200; me_wdata = 32'h55;
    t = {1'b1, 32'h200, 32'h55};
    exp_mem.push_back(t);
    t = {1'b0, 32'h300, 32'h0};
    exp_mem.push_back(t);
    exp_me.push_back(me_model);
    exp_if.push_back(mem_val(32'h300));
    me_done = 1'b0; if_done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (!if_valid) chk("prio_stall_if", {31'd0, stall_if}, 32'd1);
      if (me_valid) begin
        me_done = 1'b1;
        chk("prio_stall_me_at_valid", {31'd0, stall_me}, 32'd0);
      end
      if (if_valid) if_done = 1'b1;
      @(posedge clk); #1;
      if (me_done) me_req = 1'b0;
      if (if_done) if_req = 1'b0;
      if (me_done && if_done) break;
    end
    chk("prio_both_done", {30'd0, me_done, if_done}, 32'd3);
    if_model = mem_val(32'h300);
  endtask

  task automatic test_starvation();
    mem_txn_t t;
    int me_cnt;
    logic if_done;
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h400;
    me_req = 1'b1; me_we = 1'b0; me_addr = 32'h800; me_wdata = 32'h0;
    t = {1'b0, 32'h800, 32'h0};
    for (int i = 0; i < 4; i++) exp_mem.push_back(t);
    t = {1'b0, 32'h400, 32'h0};
    exp_mem.push_back(t);
    t = {1'b0, 32'h800, 32'h0};
    exp_mem.push_back(t);
    me_model = mem_val(32'h800);
    for (int i = 0; i < 5; i++) exp_me.push_back(me_model);
    exp_if.push_back(mem_val(32'h400));
    me_cnt = 0; if_done = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (me_valid) me_cnt++;
      if (if_valid) if_done = 1'b1;
      @(posedge clk); #1;
      if (if_done) if_req = 1'b0;
      if (me_cnt == 5) me_req = 1'b0;
      if (me_cnt == 5 && if_done) break;
    end
    chk("starve_me_count", me_cnt, 32'd5);
    chk("starve_if_done", {31'd0, if_done}, 32'd1);
    if_model = mem_val(32'h400);
  endtask

  task automatic test_flush();
    mem_txn_t t;
    // Flush in the first wait cycle of a delayed fetch
    @(posedge clk); #1;
    wait_cfg = 3;
    if_req = 1'b1; if_addr = 32'h500;
    t = {1'b0, 32'h500, 32'h0}; exp_mem.push_back(t);
    t = {1'b0, 32'h600, 32'h0}; exp_mem.push_back(t);
    exp_if.push_back(mem_val(32'h600));
    @(posedge clk); #1;
    if_flush = 1'b1; if_addr = 32'h600;
    @(negedge clk);
    chk("flush_c1_mem_req", {31'd0, mem_req}, 32'd1);
    @(posedge clk); #1;
    if_flush = 1'b0;
    for (int c = 2; c <= 4; c++) begin
      @(negedge clk);
      chk("flush_hold_mem_req", {31'd0, mem_req}, 32'd1);
      chk("flush_hold_mem_addr", mem_addr, 32'h500);
    end
    @(negedge clk);
    chk("flush_c5_mem_req", {31'd0, mem_req}, 32'd0);
    chk("flush_c5_if_valid", {31'd0, if_valid}, 32'd0);
    @(negedge clk);
    chk("flush_c6_mem_addr", mem_addr, 32'h600);
    chk("flush_c6_if_rdata", if_rdata, if_model);
    wait_if_done("flush_refetch");
    if_model = mem_val(32'h600);

    // Flush coinciding with a zero-wait completion
    wait_cfg = 0;
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h700;
    t = {1'b0, 32'h700, 32'h0}; exp_mem.push_back(t);
    t = {1'b0, 32'h780, 32'h0}; exp_mem.push_back(t);
    exp_if.push_back(mem_val(32'h780));
    @(posedge clk); #1;
    if_flush = 1'b1; if_addr = 32'h780;
    @(posedge clk); #1;
    if_flush = 1'b0;
    @(negedge clk);
    chk("coinc_c2_if_valid", {31'd0, if_valid}, 32'd0);
    @(negedge clk);
    chk("coinc_c3_if_valid", {31'd0, if_valid}, 32'd0);
    chk("coinc_c3_if_rdata", if_rdata, if_model);
    wait_if_done("coinc_refetch");
    if_model = mem_val(32'h780);

    // No fetch grant while flush is high in IDLE
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h880; if_flush = 1'b1;
    t = {1'b0, 32'h880, 32'h0}; exp_mem.push_back(t);
    exp_if.push_back(mem_val(32'h880));
    @(negedge clk);
    @(negedge clk);
    chk("idle_flush_c1_mem_req", {31'd0, mem_req}, 32'd0);
    @(posedge clk); #1;
    if_flush = 1'b0;
    @(negedge clk);
    chk("idle_flush_c2_mem_req", {31'd0, mem_req}, 32'd0);
    @(negedge clk);
    chk("idle_flush_c3_mem_req", {31'd0, mem_req}, 32'd1);
    wait_if_done("idle_flush_fetch");
    if_model = mem_val(32'h880);
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    wait_cfg = 5;
    me_req = 1'b1; me_we = 1'b0; me_addr = 32'h900;
    @(negedge clk);
    @(negedge clk);
    chk("rmid_mem_req_before", {31'd0, mem_req}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("rmid_mem_req_async", {31'd0, mem_req}, 32'd0);
    me_req = 1'b0;
    me_model = '0;
    @(posedge clk); #1;
    reset = 1'b0;
    use_ovr = 1'b1; ovr_data = 32'h0000_0BAD;
    force_ready = 1'b1;
    @(posedge clk); #1;
    force_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("rmid_no_me_valid", {31'd0, me_valid}, 32'd0);
    end
    chk("rmid_me_rdata", me_rdata, 32'd0);
    wait_cfg = 0;
    ovr_data = 32'h1234;
    run_me(1'b0, 32'h40, 32'h0);
    run_me(1'b1, 32'h44, 32'h99);
    @(negedge clk);
    chk("store_keeps_me_rdata", me_rdata, 32'h1234);
    use_ovr = 1'b0;
  endtask

  initial begin
    fork
      monitor();
      begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
      end
    join_none
    test_reset();
    test_if_fetch();
    test_priority();
    test_starvation();
    test_flush();
    test_reset_mid();
    repeat (4) @(negedge clk);
    chk("exp_mem_empty", exp_mem.size(), 32'd0);
    chk("exp_if_empty", exp_if.size(), 32'd0);
    chk("exp_me_empty", exp_me.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: maximum consecutive ME grants while IF is pending.
REQ-002 SHALL have the following ports (name, direction, width, meaning):
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- if_req  in  1  fetch request; held until if_valid
- if_addr  in  32  fetch address
- if_flush  in  1  branch taken; discard fetch in flight
- if_rdata  out  32  fetched word
- if_valid  out  1  one-cycle fetch completion pulse
- me_req  in  1  data request; held until me_valid
- me_we  in  1  1 = store, 0 = load
- me_addr  in  32  data address
- me_wdata  in  32  store data
- me_rdata  out  32  load data
- me_valid  out  1  one-cycle data completion pulse
- mem_req  out  1  memory request; held until mem_ready
- mem_we  out  1  memory write enable
- mem_addr  out  32  memory address
- mem_wdata  out  32  memory write data
- mem_ready  in  1  memory done; mem_rdata valid this cycle
- mem_rdata  in  32  memory read data
- stall_if  out  1  fetch stage must hold
- stall_me  out  1  ME stage must hold

Function
REQ-003 SHALL implement FSM states IDLE, IF_ACT, ME_ACT and IF_DROP.
REQ-004 SHALL arbitrate only in IDLE; a requester whose valid output is high in that cycle SHALL be ignored for arbitration.
REQ-005 SHALL grant ME over IF by default (IDLE->ME_ACT), unless the starvation count equals STARVE_LIMIT with if_req high, in which case IF wins (IDLE->IF_ACT).
REQ-006 SHALL increment the starvation count on each ME grant made while if_req is high, clear it on each IF grant, and saturate it at STARVE_LIMIT.
REQ-007 SHALL register mem_addr, mem_we and mem_wdata at grant; mem_req SHALL assert the cycle after grant and stay stable until the cycle mem_ready is sampled high.
REQ-008 SHALL drive mem_we=0 and mem_wdata=0 for IF transactions.
REQ-009 SHALL capture mem_rdata on mem_ready and return to IDLE.
- The matching valid pulses high the following cycle with rdata.
- Minimum latency is 3 cycles from request to valid (zero-wait memory).
REQ-010 SHALL pulse me_valid for stores as well as loads; me_rdata SHALL keep its previous value on a store.
REQ-011 SHALL move IF_ACT->IF_DROP when if_flush is high.
- The memory transaction SHALL still complete.
- The response SHALL be discarded: no if_valid, if_rdata unchanged.
- IF_DROP->IDLE on mem_ready.
REQ-012 SHALL discard the response when if_flush and mem_ready coincide in IF_ACT.
REQ-013 SHALL not grant IF in an IDLE cycle where if_flush is high.
REQ-014 SHALL drive stall_if = if_req AND NOT if_valid, and stall_me = me_req AND NOT me_valid, combinationally.
REQ-015 SHALL never have more than one memory transaction outstanding.

Reset
REQ-016 SHALL on reset enter IDLE, clear the starvation count, and drive all outputs to 0, including mem_req, immediately (asynchronous).
REQ-017 SHALL abandon any in-flight transaction on reset and generate no valid for it.
- mem_ready arriving after reset deassertion while in IDLE SHALL be ignored.

Structure
REQ-018 SHALL take FSM state encoding (2-bit) and grant-source constants from the shared pipeline package, alongside the existing ALU op definitions.
REQ-019 SHALL be a single module with no sub-modules; the starvation counter is inline.

Verification
REQ-020 Zero-wait, if_req with if_addr=0x100, mem_rdata=0xDEADBEEF -> mem_req in cycle 1, if_valid in cycle 3 with if_rdata=0xDEADBEEF.
REQ-021 if_req and me_req (store, me_addr=0x200, me_wdata=0x55) simultaneous -> ME served first with mem_we=1 and mem_wdata=0x55, then IF; stall_if high throughout.
REQ-022 STARVE_LIMIT=4, me_req held re-asserted continuously with if_req high -> 4 ME grants, then 1 IF grant, then ME resumes.
REQ-023 IF_ACT with mem_ready delayed 3 cycles, if_flush pulsed in the first wait cycle -> mem_req stays high until mem_ready, no if_valid, next IF fetch at the new address.
REQ-024 Reset asserted mid ME_ACT -> mem_req=0 that cycle; a late mem_ready after reset yields no me_valid; the next request completes normally.
REQ-025 Load at me_addr=0x40 returning 0x1234, followed by a store -> me_rdata stays 0x1234 after the store's me_valid.
